// File: rtl/spec_pkg.sv
// Shared widths, FSM encoding and address packing for the spectrum readout block.
package spec_pkg;
  localparam int IDX_W      = 10;
  localparam int BIN_W      = 4;
  localparam int DATA_W     = 32;
  localparam int RD_LAT     = 2;
  localparam int SKID_DEPTH = RD_LAT + 2;
  localparam int ADDR_W     = BIN_W + IDX_W;
  localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic vld;
    logic last;
    logic fe;
  } tag_t;

  typedef struct packed {
    logic              fe;
    logic              last;
    logic [DATA_W-1:0] dat;
  } beat_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [BIN_W-1:0] bin,
                                                  input logic [IDX_W-1:0] idx);
    return {bin, idx};
  endfunction
endpackage

// File: rtl/spec_readout_if.sv
// Spectrum word stream towards the upload FIFO (valid/ready, last per bin, frame end).
interface spec_readout_if;
  import spec_pkg::*;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              m_frame_end;

  modport master (output m_data, output m_valid, output m_last, output m_frame_end, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, input m_frame_end, output m_ready);
endinterface

// File: rtl/spec_skid_fifo.sv
// First-word-fall-through FIFO with occupancy count; head valid whenever not empty.
// Push when full is dropped unless a pop happens in the same cycle.
module spec_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 34,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/spec_readout.sv
// Streams accumulated spectra out of the DPRAM bin-major; first word RD_LAT+2 cycles after start.
// Reads are credit-limited by skid space, so downstream stalls never drop data. SPEC_BG_SUB_EN adds background subtraction.
module spec_readout
  import spec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BIN_W:0]    num_bins,
  input  logic [IDX_W:0]    num_points,
  output logic [ADDR_W-1:0] rdaddr_out,
  output logic              rden,
  input  logic [DATA_W-1:0] rddata,
`ifdef SPEC_BG_SUB_EN
  output logic [IDX_W-1:0]  bg_rdaddr,
  input  logic [DATA_W-1:0] bg_rddata,
`endif
  spec_readout_if.master    m,
  output logic              busy,
  output logic              done
);
  state_e            state_q, state_d;
  logic [BIN_W:0]    nb_q, nb_d;
  logic [IDX_W:0]    np_q, np_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  tag_t              tag_q [RD_LAT];
  tag_t              tag_d;
  int unsigned       in_flight;
  logic              last_idx, last_bin, credit_ok, pop;
  logic              skid_empty;
  logic [CNT_W-1:0]  skid_cnt;
  logic [DATA_W-1:0] push_word;
  beat_t             head;

  assign last_idx  = ({1'b0, idx_q} == np_q - 1'b1);
  assign last_bin  = ({1'b0, bin_q} == nb_q - 1'b1);
  assign credit_ok = (in_flight + 32'(skid_cnt)) < 32'(SKID_DEPTH);
  assign pop       = m.m_valid & m.m_ready;

  always_comb begin
    in_flight = 0;
    for (int i = 0; i < RD_LAT; i++) in_flight += {31'd0, tag_q[i].vld};
  end

  always_comb begin
    state_d = state_q;
    nb_d    = nb_q;
    np_d    = np_q;
    bin_d   = bin_q;
    idx_d   = idx_q;
    rden    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_READ;
        nb_d    = (num_bins == '0) ? (BIN_W+1)'(1) : num_bins;
        np_d    = (num_points == '0) ? (IDX_W+1)'(1) : num_points;
        bin_d   = '0;
        idx_d   = '0;
      end
      ST_READ: if (credit_ok) begin
        rden = 1'b1;
        if (last_idx) begin
          idx_d = '0;
          if (last_bin) state_d = ST_DRAIN;
          else          bin_d   = bin_q + 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      // Leave as the final word is accepted so done lands one cycle after it.
      ST_DRAIN: if (in_flight == 0 && (skid_empty || (skid_cnt == CNT_W'(1) && pop)))
        state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      nb_q    <= '0;
      np_q    <= '0;
      bin_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      nb_q    <= nb_d;
      np_q    <= np_d;
      bin_q   <= bin_d;
      idx_q   <= idx_d;
    end
  end

  assign tag_d = '{vld: rden, last: last_idx, fe: last_idx & last_bin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign rdaddr_out = pack_addr(bin_q, idx_q);
  assign busy       = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);

`ifdef SPEC_BG_SUB_EN
  assign bg_rdaddr = idx_q;
  assign push_word = (rddata >= bg_rddata) ? rddata - bg_rddata : '0;
`else
  assign push_word = rddata;
`endif

  spec_skid_fifo #(.DEPTH(SKID_DEPTH), .W($bits(beat_t)), .CW(CNT_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (tag_q[RD_LAT-1].vld),
    .push_dat_i ({tag_q[RD_LAT-1].fe, tag_q[RD_LAT-1].last, push_word}),
    .pop_i      (pop),
    .head_o     (head),
    .empty_o    (skid_empty),
    .count_o    (skid_cnt)
  );

  assign m.m_valid     = ~skid_empty;
  assign m.m_data      = skid_empty ? '0 : head.dat;
  assign m.m_last      = ~skid_empty & head.last;
  assign m.m_frame_end = ~skid_empty & head.fe;
endmodule

// File: tb/tb_spec_readout.sv
// Scoreboard bench for spec_readout: DPRAM model, ready patterns, credit and framing checks.
`timescale 1ns/1ps
module tb_spec_readout;
  import spec_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [BIN_W:0]    num_bins;
  logic [IDX_W:0]    num_points;
  logic [ADDR_W-1:0] rdaddr_out;
  logic              rden;
  logic [DATA_W-1:0] rddata;
  logic              busy, done;
`ifdef SPEC_BG_SUB_EN
  logic [IDX_W-1:0]  bg_rdaddr;
  logic [DATA_W-1:0] bg_rddata;
  logic [IDX_W-1:0]  bg_pipe [RD_LAT];
`endif

  spec_readout_if mif();

  spec_readout dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_bins   (num_bins),
    .num_points (num_points),
    .rdaddr_out (rdaddr_out),
    .rden       (rden),
    .rddata     (rddata),
`ifdef SPEC_BG_SUB_EN
    .bg_rdaddr  (bg_rdaddr),
    .bg_rddata  (bg_rddata),
`endif
    .m          (mif),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, words = 0, done_cnt = 0, fe_cyc = -100, outstanding = 0, rdy_cnt = 0;
  bit bp_mode = 1'b0, bg_mode = 1'b0;
  logic [DATA_W+1:0] exp_q [$];
  logic [ADDR_W-1:0] a_pipe [RD_LAT];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    logic [IDX_W-1:0] ix;
    ix = a[IDX_W-1:0];
    if (bg_mode) return (ix == '0) ? DATA_W'(100) : DATA_W'(5);
    return DATA_W'(a);
  endfunction

  function automatic logic [DATA_W+1:0] exp_item(input int b, input int i, input int nb, input int np);
    logic [DATA_W-1:0] w;
    logic lst, fe;
    lst = (i == np - 1);
    fe  = lst && (b == nb - 1);
    if (bg_mode) w = (i == 0) ? DATA_W'(70) : DATA_W'(0);
    else         w = DATA_W'((b << IDX_W) | i);
    return {fe, lst, w};
  endfunction

  // DPRAM model: address captured each edge, data appears RD_LAT cycles later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    a_pipe[0] <= rdaddr_out;
    for (int i = 1; i < RD_LAT; i++) a_pipe[i] <= a_pipe[i-1];
`ifdef SPEC_BG_SUB_EN
    bg_pipe[0] <= bg_rdaddr;
    for (int i = 1; i < RD_LAT; i++) bg_pipe[i] <= bg_pipe[i-1];
`endif
  end
  assign rddata = ram_word(a_pipe[RD_LAT-1]);
`ifdef SPEC_BG_SUB_EN
  assign bg_rddata = bg_mode ? ((bg_pipe[RD_LAT-1] == '0) ? DATA_W'(30) : DATA_W'(9)) : '0;
`endif

  initial begin
    mif.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_cnt++;
      mif.m_ready = bp_mode ? (rdy_cnt % 3 == 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    logic acc;
    logic [DATA_W+1:0] e;
    if (rst) begin
      outstanding = 0;
    end else begin
      if (rden) chk("credit", {63'd0, outstanding < SKID_DEPTH}, 64'd1);
      acc = mif.m_valid && mif.m_ready;
      if (acc) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", {mif.m_frame_end, mif.m_last, mif.m_data}, '1);
        end else begin
          e = exp_q.pop_front();
          chk("word", {mif.m_frame_end, mif.m_last, mif.m_data}, e);
        end
        words++;
        if (mif.m_frame_end) fe_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_gap", cyc - fe_cyc, 1);
        chk("done_drained", exp_q.size(), 0);
      end
      outstanding = outstanding + (rden ? 1 : 0) - (acc ? 1 : 0);
    end
  end

  task automatic run_frame(input int nb, input int np, input bit bp, input bit dbl);
    int enb, enp, w0, d0, lat, budget;
    enb = (nb == 0) ? 1 : nb;
    enp = (np == 0) ? 1 : np;
    w0 = words; d0 = done_cnt; lat = 0;
    budget = enb * enp * 4 + 50;
    for (int b = 0; b < enb; b++)
      for (int i = 0; i < enp; i++) exp_q.push_back(exp_item(b, i, enb, enp));
    bp_mode = bp;
    @(negedge clk);
    num_bins = (BIN_W+1)'(nb);
    num_points = (IDX_W+1)'(np);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", busy, 1);
    for (int n = 1; n < budget && done_cnt == d0; n++) begin
      if (lat == 0 && mif.m_valid) lat = n;
      start = (dbl && n == 30);
      @(negedge clk);
    end
    start = 1'b0;
    if (done_cnt == d0) chk("timeout", 0, 1);
    chk("first_latency", lat, RD_LAT + 2);
    repeat (3) @(negedge clk);
    chk("word_count", words - w0, enb * enp);
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_idle", busy, 0);
    chk("queue_empty", exp_q.size(), 0);
    bp_mode = 1'b0;
  endtask

  initial begin
    int w0, d0;
    rst = 1'b1; start = 1'b0; num_bins = '0; num_points = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {rdaddr_out, rden, mif.m_data, mif.m_valid, mif.m_last, mif.m_frame_end, busy, done}, '0);
    rst = 1'b0;

    run_frame(2, 4, 1'b0, 1'b0);
    run_frame(1, 1024, 1'b1, 1'b0);
    run_frame(16, 1024, 1'b0, 1'b0);
    run_frame(3, 64, 1'b0, 1'b1);
    run_frame(0, 0, 1'b0, 1'b0);
    run_frame(2, 5, 1'b1, 1'b0);

    // Abort a frame after 100 accepted words.
    w0 = words; d0 = done_cnt;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 128; i++) exp_q.push_back(exp_item(b, i, 2, 128));
    @(negedge clk);
    num_bins = 2; num_points = 128; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 2000 && words - w0 < 100; n++) @(negedge clk);
    chk("pre_reset_words", {63'd0, words - w0 >= 100}, 64'd1);
    #2 rst = 1'b1;
    #1 chk("midrst_outs", {rdaddr_out, rden, mif.m_data, mif.m_valid, mif.m_last, mif.m_frame_end, busy, done}, '0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_done_after_rst", done_cnt - d0, 0);
    run_frame(2, 4, 1'b0, 1'b0);

`ifdef SPEC_BG_SUB_EN
    bg_mode = 1'b1;
    run_frame(1, 2, 1'b0, 1'b0);
    bg_mode = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
